// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running pixel/line counters with an optional clock divider,
// producing registered syncs, visible flag, start pulses and a frame counter, all zero-skew.
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int PIX_DIV   = 1,
  parameter int COL_W     = 12,
  parameter int ROW_W     = 11,
  parameter int FRAME_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic               pix_tick,
  output logic [COL_W-1:0]   col,
  output logic [ROW_W-1:0]   row,
  output logic               visible,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  generate
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 || V_FRONT < 1 || V_SYNC < 1 ||
        V_BACK < 1 || PIX_DIV < 1 ||
        longint'(H_TOTAL - 1) >= (longint'(1) << COL_W) ||
        longint'(V_TOTAL - 1) >= (longint'(1) << ROW_W)) begin : g_bad_params
      $error("vga_timing_gen: illegal timing parameters or counter widths");
    end
  endgenerate

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_TOTAL - 1);
  localparam logic [COL_W-1:0] H_VIS    = COL_W'(H_VISIBLE);
  localparam logic [ROW_W-1:0] V_VIS    = ROW_W'(V_VISIBLE);
  localparam logic [COL_W-1:0] HS_BEG   = COL_W'(H_VISIBLE + H_FRONT);
  localparam logic [COL_W-1:0] HS_END   = COL_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [ROW_W-1:0] VS_BEG   = ROW_W'(V_VISIBLE + V_FRONT);
  localparam logic [ROW_W-1:0] VS_END   = ROW_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]   div, div_n;
  logic [COL_W-1:0]   col_n;
  logic [ROW_W-1:0]   row_n;
  logic [FRAME_W-1:0] frame_n;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    pix_tick = enable && (div == DIV_LAST);
    div_n    = (div == DIV_LAST) ? '0 : div + 1'b1;
    col_n    = col;
    row_n    = row;
    frame_n  = frame_count;
    if (pix_tick) begin
      if (col == COL_LAST) begin
        col_n = '0;
        if (row == ROW_LAST) begin
          row_n   = '0;
          frame_n = frame_count + 1'b1;
        end else begin
          row_n = row + 1'b1;
        end
      end else begin
        col_n = col + 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div         <= '0;
      col         <= COL_LAST;
      row         <= ROW_LAST;
      visible     <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '1;
    end else begin
      // Pulses derive from the next position so they stay aligned with col/row.
      line_start  <= pix_tick && (col_n == '0);
      frame_start <= pix_tick && (col_n == '0) && (row_n == '0);
      if (enable) div <= div_n;
      if (pix_tick) begin
        col         <= col_n;
        row         <= row_n;
        frame_count <= frame_n;
        visible     <= (col_n < H_VIS) && (row_n < V_VIS);
        hsync       <= ((col_n >= HS_BEG) && (col_n < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync       <= ((row_n >= VS_BEG) && (row_n < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
      end
    end
  end

endmodule
